// File: rtl/matmul_ctrl_part2.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_ctrl_part2
//  Purpose  : Sequencing controller for the part-2 matrix-vector datapath.
//             Loads N*N weights (row-major) and then N X elements over a
//             valid/ready stream. It then steps the datapath through
//             CLEAR / MAC / OUT for each row and hands every finished
//             y[r] to the consumer over a valid/ready handshake.
//  Ports    : clk, rst (async, active-low)
//             in_valid / in_ready          - upstream word handshake
//             addr_x, wr_en_x              - X memory address / write strobe
//             addr_w, wr_en_w              - W memory address / write strobe
//             clear_acc, en_acc            - accumulator clear / enable
//             out_valid / out_ready        - result handshake
//             out_last, row_idx            - result qualifiers
//  Revision : 1.0  initial release
// ============================================================================
module matmul_ctrl_part2 #(
  parameter int N   = 3,
  parameter int AXW = 2,
  parameter int AWW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [AXW-1:0] addr_x,
  output logic           wr_en_x,
  output logic [AWW-1:0] addr_w,
  output logic           wr_en_w,
  output logic           clear_acc,
  output logic           en_acc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [1:0]     row_idx
);

  typedef enum logic [2:0] {
    LOAD_W = 3'd0,
    LOAD_X = 3'd1,
    CLEAR  = 3'd2,
    MAC    = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [AWW-1:0] C_LAST_W   = AWW'(N * N - 1);
  localparam logic [AWW-1:0] C_LAST_X   = AWW'(N - 1);
  localparam logic [AXW-1:0] C_LAST_K   = AXW'(N - 1);
  localparam logic [1:0]     C_LAST_ROW = 2'(N - 1);
  localparam logic [AWW-1:0] C_N_W      = AWW'(N);

  state_t         r_state, w_state_nxt;
  logic [AWW-1:0] r_cnt,   w_cnt_nxt;
  logic [AXW-1:0] r_k,     w_k_nxt;
  logic [1:0]     r_r,     w_r_nxt;

  logic           w_load;
  logic           w_accept;
  logic [AWW-1:0] w_row_base;

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign w_load     = (r_state == LOAD_W) || (r_state == LOAD_X);
  assign in_ready   = w_load & rst;
  assign w_accept   = in_valid & in_ready;
  assign w_row_base = C_N_W * AWW'(r_r);
  assign row_idx    = r_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD_W;
      r_cnt   <= '0;
      r_k     <= '0;
      r_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_r     <= w_r_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_r_nxt     = r_r;
    addr_x      = '0;
    addr_w      = '0;
    wr_en_x     = 1'b0;
    wr_en_w     = 1'b0;
    clear_acc   = 1'b0;
    en_acc      = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;

    case (r_state)
      LOAD_W: begin
        addr_w  = r_cnt;
        wr_en_w = w_accept;
        if (w_accept) begin
          if (r_cnt == C_LAST_W) begin
            w_state_nxt = LOAD_X;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      LOAD_X: begin
        // cnt never exceeds N-1 here, so the truncation stays in range.
        addr_x  = r_cnt[AXW-1:0];
        wr_en_x = w_accept;
        if (w_accept) begin
          if (r_cnt == C_LAST_X) begin
            w_state_nxt = CLEAR;
            w_cnt_nxt   = '0;
            w_r_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      CLEAR: begin
        clear_acc   = 1'b1;
        w_k_nxt     = '0;
        w_state_nxt = MAC;
      end

      MAC: begin
        // Memory reads are combinational: the product for (r,k) is
        // presented to the accumulator in this same cycle.
        addr_x = r_k;
        addr_w = w_row_base + AWW'(r_k);
        en_acc = 1'b1;
        if (r_k == C_LAST_K) begin
          w_state_nxt = OUT;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        out_last  = (r_r == C_LAST_ROW);
        if (out_ready) begin
          if (r_r == C_LAST_ROW) begin
            w_state_nxt = LOAD_W;
            w_cnt_nxt   = '0;
          end else begin
            w_r_nxt     = r_r + 1'b1;
            w_state_nxt = CLEAR;
          end
        end
      end

      default: begin
        w_state_nxt = LOAD_W;
        w_cnt_nxt   = '0;
        w_k_nxt     = '0;
        w_r_nxt     = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_ctrl_part2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_ctrl_part2
//  Purpose  : Self-checking bench for matmul_ctrl_part2. A small behavioural
//             datapath (W/X memories + accumulator) is driven by the DUT's
//             strobes so row results can be compared against hand-computed
//             values.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_matmul_ctrl_part2;

  localparam int N   = 3;
  localparam int AXW = 2;
  localparam int AWW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [AXW-1:0] addr_x;
  logic           wr_en_x;
  logic [AWW-1:0] addr_w;
  logic           wr_en_w;
  logic           clear_acc;
  logic           en_acc;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [1:0]     row_idx;
  logic [13:0]    data_in;

  always #5 clk = ~clk;

  matmul_ctrl_part2 #(.N(N), .AXW(AXW), .AWW(AWW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_w    (addr_w),
    .wr_en_w   (wr_en_w),
    .clear_acc (clear_acc),
    .en_acc    (en_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .row_idx   (row_idx)
  );

  // Behavioural datapath
  logic signed [13:0] wmem [0:15];
  logic signed [13:0] xmem [0:3];
  logic signed [27:0] acc;
  logic signed [27:0] w_ext, x_ext;

  always_comb begin
    w_ext = wmem[addr_w];
    x_ext = xmem[addr_x];
  end

  always_ff @(posedge clk) begin
    if (wr_en_w) wmem[addr_w] <= data_in;
    if (wr_en_x) xmem[addr_x] <= data_in;
    if (clear_acc)   acc <= '0;
    else if (en_acc) acc <= acc + w_ext * x_ext;
  end

  typedef struct packed {
    logic [8:0][13:0] w;
    logic [2:0][13:0] x;
    logic [2:0][27:0] y;
  } vec_t;

  vec_t vecs [4];
  int   wl [9];
  int   xl [3];
  int   yl [3];

  int tests = 0;
  int fails = 0;
  int n_wr_w, n_wr_x, exp_aw, exp_ax;

  function automatic vec_t mk_vec();
    vec_t v;
    for (int i = 0; i < 9; i++) v.w[i] = 14'(wl[i]);
    for (int i = 0; i < 3; i++) v.x[i] = 14'(xl[i]);
    for (int i = 0; i < 3; i++) v.y[i] = 28'(yl[i]);
    return v;
  endfunction

  function automatic logic [14:0] ctl_vec();
    return {in_ready, wr_en_x, wr_en_w, clear_acc, en_acc, out_valid,
            out_last, row_idx, addr_x, addr_w};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample point: falling edge. Also screens strobe invariants and write order.
  task automatic at_neg();
    @(negedge clk);
    if (rst) begin
      if (clear_acc && en_acc) begin
        fails++;
        $display("FAIL clear_en_overlap: got clear=1 en=1 expected not both");
      end
      if ((wr_en_w || wr_en_x) && !(in_valid && in_ready)) begin
        fails++;
        $display("FAIL stray_write: got wr_w=%0b wr_x=%0b expected 0 without accept", wr_en_w, wr_en_x);
      end
      if (wr_en_w) begin
        if (addr_w !== 4'(exp_aw)) begin
          fails++;
          $display("FAIL addr_w_order: got %0d expected %0d", addr_w, exp_aw);
        end
        exp_aw++;
        n_wr_w++;
      end
      if (wr_en_x) begin
        if (addr_x !== 2'(exp_ax)) begin
          fails++;
          $display("FAIL addr_x_order: got %0d expected %0d", addr_x, exp_ax);
        end
        exp_ax++;
        n_wr_x++;
      end
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [13:0] d, input bit bursty);
    bit ok;
    int guard;
    if (bursty) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        at_neg();
        to_drive();
      end
    end
    in_valid = 1'b1;
    data_in  = d;
    guard    = 0;
    do begin
      at_neg();
      ok = in_ready;
      to_drive();
      guard++;
    end while (!ok && guard < 40);
    if (!ok) begin
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input bit bursty);
    exp_aw = 0; exp_ax = 0; n_wr_w = 0; n_wr_x = 0;
    for (int i = 0; i < 9; i++) send_word(v.w[i], bursty);
    for (int i = 0; i < 3; i++) send_word(v.x[i], bursty);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      at_neg();
      n++;
    end while (!out_valid && n < 64);
    if (!out_valid) begin
      fails++;
      $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 64 cycles");
    end
  endtask

  // Called right after the last X accept edge with out_ready high.
  task automatic collect_frame(input vec_t v);
    int n;
    for (int r = 0; r < 3; r++) begin
      wait_out(n);
      check("row_latency", 28'(n), 28'd5);
      check("row_idx", 28'(row_idx), 28'(r));
      check("out_last", 28'(out_last), 28'(r == 2));
      check("row_result", acc, v.y[r]);
      to_drive();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;

    wl = '{1, 2, 3, 4, 5, 6, 7, 8, 9};   xl = '{1, 2, 3};  yl = '{14, 32, 50};
    vecs[0] = mk_vec();
    wl = '{-2, -2, -2, -2, -2, -2, -2, -2, -2}; xl = '{3, -1, 4}; yl = '{-12, -12, -12};
    vecs[1] = mk_vec();
    wl = '{1, 0, 0, 0, 1, 0, 0, 0, 1};   xl = '{5, 6, 7};  yl = '{5, 6, 7};
    vecs[2] = mk_vec();
    wl = '{2, 0, -1, 3, 1, 1, -4, 5, 0}; xl = '{10, -3, 2}; yl = '{18, 29, -55};
    vecs[3] = mk_vec();

    // Reset state
    repeat (3) to_drive();
    at_neg();
    check("reset_outputs", 28'(ctl_vec()), 28'd0);
    to_drive();
    rst = 1'b1;
    at_neg();
    check("in_ready_after_reset", 28'(in_ready), 28'd1);
    to_drive();

    // Table-driven frames, streamed back to back
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v], 1'b0);
      collect_frame(vecs[v]);
      at_neg();
      check("b2b_in_ready", 28'(in_ready), 28'd1);
      to_drive();
    end

    // Bursty input: same results, exact write pulse counts
    send_frame(vecs[0], 1'b1);
    check("wr_en_w_count", 28'(n_wr_w), 28'd9);
    check("wr_en_x_count", 28'(n_wr_x), 28'd3);
    collect_frame(vecs[0]);

    // Backpressure on row 1, with stray in_valid that must be ignored
    send_frame(vecs[0], 1'b0);
    wait_out(n);
    check("bp_row0", acc, 28'd14);
    to_drive();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    wait_out(n);
    check("bp_row1_latency", 28'(n), 28'd5);
    for (int c = 0; c < 7; c++) begin
      check("bp_hold_valid", 28'(out_valid), 28'd1);
      check("bp_hold_value", acc, 28'd32);
      check("bp_hold_row", 28'(row_idx), 28'd1);
      check("bp_hold_strobes", 28'({en_acc, clear_acc}), 28'd0);
      check("bp_hold_in_ready", 28'(in_ready), 28'd0);
      to_drive();
      if (c < 6) at_neg();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    at_neg();
    check("bp_release_value", acc, 28'd32);
    to_drive();
    wait_out(n);
    check("bp_row2_latency", 28'(n), 28'd5);
    check("bp_row2_value", acc, 28'd50);
    check("bp_row2_last", 28'(out_last), 28'd1);
    to_drive();

    // Reset during row 1 MAC, then reload identity frame
    send_frame(vecs[0], 1'b0);
    wait_out(n);
    to_drive();
    at_neg();
    at_neg();
    check("mid_mac_en_acc", 28'(en_acc), 28'd1);
    check("mid_mac_row", 28'(row_idx), 28'd1);
    rst = 1'b0;
    #1;
    check("mid_mac_reset_outputs", 28'(ctl_vec()), 28'd0);
    to_drive();
    to_drive();
    rst = 1'b1;
    at_neg();
    check("in_ready_after_mid_reset", 28'(in_ready), 28'd1);
    to_drive();
    send_frame(vecs[2], 1'b0);
    collect_frame(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_ctrl_part2.md
# matmul_ctrl_part2

Sequencing controller directly upstream of the part-2 matrix-vector datapath. It accepts a stream of 14-bit words over a valid/ready handshake: 9 weights of a 3×3 W matrix in row-major order, then the 3 elements of the X vector. It then drives the datapath's address, write, clear and accumulate strobes to compute y[r] = Σ_k W[r][k]·X[k] for r = 0..2. It presents each finished row result to a downstream consumer with a valid/ready handshake. Input data itself is wired straight to the datapath `input_data`; this block only generates control.

## Interface
- `N`, 3: matrix dimension; W holds N×N words, X holds N.
- `AXW`, 2: width of `addr_x`.
- `AWW`, 4: width of `addr_w`.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream word valid; the word is on the datapath `input_data` bus this cycle.
- `in_ready`  out  1  controller accepts a word this cycle.
- `addr_x`  out  AXW  X memory address.
- `wr_en_x`  out  1  X memory write strobe.
- `addr_w`  out  AWW  W memory address.
- `wr_en_w`  out  1  W memory write strobe.
- `clear_acc`  out  1  synchronous accumulator clear.
- `en_acc`  out  1  accumulator enable.
- `out_valid`  out  1  datapath `output_data` holds finished y[`row_idx`].
- `out_ready`  in  1  downstream accepts the result.
- `out_last`  out  1  qualifies `out_valid` for row N-1.
- `row_idx`  out  2  row index of the current result.

## Operation
- The FSM has five states: LOAD_W, LOAD_X, CLEAR, MAC, OUT.
- Counters:
  - `cnt`: load index, 0..N·N-1.
  - `k`: MAC index, 0..N-1.
  - `r`: row, 0..N-1.
- A word is accepted when `in_valid & in_ready`.
- `in_ready` = (state ∈ {LOAD_W, LOAD_X}) & `rst`.
- LOAD_W:
  - `addr_w`=`cnt`, `wr_en_w` = accept.
  - On an accept with `cnt`=N·N-1, go to LOAD_X with `cnt`←0. Otherwise `cnt`++ on each accept.
- LOAD_X:
  - `addr_x`=`cnt`, `wr_en_x` = accept.
  - On an accept with `cnt`=N-1, go to CLEAR with `r`←0.
- CLEAR: `clear_acc`=1 for one cycle, `k`←0, then go to MAC.
- MAC:
  - `addr_x`=`k`, `addr_w`=N·`r`+`k`, `en_acc`=1.
  - Memory reads are combinational, so the product is valid in the same cycle.
  - `k`++ each cycle. After `k`=N-1, go to OUT.
- OUT:
  - `out_valid`=1, `row_idx`=`r`, `out_last`=(`r`=N-1). `en_acc`=0, so the accumulator holds.
  - On `out_ready`: if `r`=N-1, go to LOAD_W with `cnt`←0; else `r`++ and go to CLEAR.
  - `out_valid` stays high, and `row_idx` stays stable, until accepted.
- Write strobes are never asserted outside the load states. `clear_acc` and `en_acc` are never asserted together.
- Addresses are don't-care when not in use but must stay within range (<N, <N·N).
- Arithmetic is in the datapath (28-bit saturating accumulate). This block performs no arithmetic beyond counters.

## Timing
- Reset (`rst`=0, asynchronous):
  - State LOAD_W; all counters 0.
  - Outputs: `in_ready`=0, `wr_en_x`=`wr_en_w`=`clear_acc`=`en_acc`=`out_valid`=`out_last`=0, `row_idx`=0, addresses 0.
  - `in_ready` rises in the first cycle after deassertion.
- Load: 12 accepted words minimum, one per cycle when `in_valid` is held high. Gaps with `in_valid`=0 stall without side effects.
- Per row: 1 CLEAR + N MAC + ≥1 OUT cycles.
- Latency from the last X accept to the first `out_valid`: N+1 cycles. That is 4 with default N, so `out_valid` is seen in the 5th cycle after the accept edge.
- With `out_ready` tied high, the full compute phase takes 3·5 = 15 cycles, then the block returns to LOAD_W.
- Reset mid-operation (any state) aborts immediately. The next frame must reload all 12 words; memory contents are not relied on.
- `in_valid` during CLEAR/MAC/OUT is ignored (`in_ready`=0); no write occurs.
- Backpressure: `out_ready`=0 holds OUT indefinitely with the accumulator unchanged.

## Test plan
- Basic frame: W=1..9 row-major, X=1,2,3, `out_ready`=1 → `output_data`=14, 32, 50 on three `out_valid` cycles, `row_idx` 0,1,2, `out_last` only on 50.
- Bursty input: the same frame with `in_valid` toggled randomly → identical results. Exactly 9 `wr_en_w` and 3 `wr_en_x` pulses, with addresses 0..8 and 0..2 in order.
- Backpressure: hold `out_ready`=0 for 7 cycles on row 1 → `out_valid`=1 and 32 stable throughout, no `en_acc`/`clear_acc` asserted, then release → 50 follows 5 cycles later.
- Negative values: W all -2, X = 3,-1,4 → all rows -12.
- Reset mid-MAC: drop `rst` during row 1 MAC → all outputs go to reset values immediately. Reload with W=identity, X=5,6,7 → results 5, 6, 7.
- Back-to-back frames: a second frame streamed right after `out_last` is accepted → `in_ready`=1 the following cycle and the correct second results.
